// File: rtl/cw_encode_ctrl.sv
// Sequencer for the constant-weight encoder core: serialises host bytes into the
// core's bit interface, issues start, and collects codewords into a tagged output FIFO.
module cw_encode_ctrl #(
    parameter int CW_WORDS    = 38,
    parameter int OFIFO_DEPTH = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    output logic        busy,
    input  logic        msg_valid,
    input  logic [7:0]  msg_byte,
    output logic        msg_ready,
    output logic        enc_start,
    output logic        enc_bin_msg,
    output logic        enc_fifoempty,
    input  logic        enc_readfifo,
    input  logic [9:0]  enc_cw_word,
    input  logic        enc_ready,
    input  logic        enc_done,
    output logic        out_valid,
    output logic [9:0]  out_word,
    output logic [5:0]  out_idx,
    output logic        out_last,
    input  logic        out_ready,
    output logic        frame_done,
    output logic [1:0]  err
);

    localparam int PW  = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
    localparam int LW  = PW + 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [1:0]     state;
    logic [15:0]    bit_buf;
    logic [4:0]     bit_cnt;
    logic [5:0]     word_cnt;
    logic [WDW-1:0] wd_cnt;
    logic [1:0]     err_q;
    logic           busy_q;
    logic           enc_start_q;
    logic           frame_done_q;

    logic [15:0]    fifo_mem [OFIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic           out_valid_q;
    logic [9:0]     out_word_q;
    logic [5:0]     out_idx_q;
    logic           out_last_q;

    logic           in_run;
    logic           fifo_tight;
    logic           byte_acc;
    logic           bit_pop;
    logic           cw_push_req;
    logic           fifo_push;
    logic           fifo_pop;
    logic           activity;
    logic           wd_expire;
    logic [15:0]    buf_shift;
    logic [4:0]     cnt_base;
    logic [15:0]    buf_nxt;
    logic [4:0]     cnt_nxt;
    logic [5:0]     wc_nxt;
    logic [15:0]    push_data;
    logic [PW-1:0]  rd_nxt;
    logic [LW-1:0]  level_nxt;
    logic [15:0]    head_nxt;

    assign in_run     = (state == ST_RUN);
    // Keep two free slots so a codeword already in the core's pipeline still fits.
    assign fifo_tight = (level >= LW'(OFIFO_DEPTH - 1));

    assign enc_fifoempty = (bit_cnt == 5'd0) || fifo_tight;
    assign msg_ready     = in_run && (bit_cnt <= 5'd8);

    assign byte_acc    = msg_valid && msg_ready;
    assign bit_pop     = in_run && enc_readfifo && !enc_fifoempty;
    assign cw_push_req = in_run && enc_ready;
    assign fifo_pop    = out_ready && (level != '0);
    assign fifo_push   = cw_push_req && ((level != LW'(OFIFO_DEPTH)) || fifo_pop);
    assign push_data   = {enc_cw_word, word_cnt};

    assign activity  = enc_readfifo || enc_ready || byte_acc;
    assign wd_expire = in_run && !activity && (wd_cnt == WDW'(TIMEOUT - 1));

    always_comb begin
        buf_shift = bit_pop ? {bit_buf[14:0], 1'b0} : bit_buf;
        cnt_base  = bit_cnt - {4'd0, bit_pop};
        buf_nxt   = buf_shift;
        cnt_nxt   = cnt_base;
        // Bits are MSB-aligned; a new byte lands directly behind the valid bits.
        if (byte_acc) begin
            buf_nxt = buf_shift | ({msg_byte, 8'h00} >> cnt_base);
            cnt_nxt = cnt_base + 5'd8;
        end
    end

    always_comb begin
        wc_nxt = word_cnt;
        if (cw_push_req && (word_cnt != 6'd63)) begin
            wc_nxt = word_cnt + 6'd1;
        end
    end

    always_comb begin
        rd_nxt    = fifo_pop ? (rd_ptr + PW'(1)) : rd_ptr;
        level_nxt = level + LW'(fifo_push) - LW'(fifo_pop);
        head_nxt  = (fifo_push && (wr_ptr == rd_nxt)) ? push_data : fifo_mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr      <= rd_nxt;
            level       <= level_nxt;
            out_valid_q <= (level_nxt != '0);
            if (level_nxt != '0) begin
                out_word_q <= head_nxt[15:6];
                out_idx_q  <= head_nxt[5:0];
                out_last_q <= (head_nxt[5:0] == 6'(CW_WORDS - 1));
            end else begin
                out_word_q <= '0;
                out_idx_q  <= '0;
                out_last_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_buf      <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            wd_cnt       <= '0;
            err_q        <= '0;
            busy_q       <= 1'b0;
            enc_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state       <= ST_START;
                        busy_q      <= 1'b1;
                        enc_start_q <= 1'b1;
                        bit_buf     <= '0;
                        bit_cnt     <= '0;
                        word_cnt    <= '0;
                        wd_cnt      <= '0;
                        err_q       <= '0;
                    end
                end
                ST_START: begin
                    enc_start_q <= 1'b0;
                    state       <= ST_RUN;
                end
                ST_RUN: begin
                    bit_buf  <= buf_nxt;
                    bit_cnt  <= cnt_nxt;
                    word_cnt <= wc_nxt;
                    wd_cnt   <= activity ? '0 : (wd_cnt + WDW'(1));
                    if (enc_done) begin
                        if (wc_nxt != 6'(CW_WORDS)) begin
                            err_q[0] <= 1'b1;
                        end
                        state   <= ST_FLUSH;
                        bit_buf <= '0;
                        bit_cnt <= '0;
                    end else if (wd_expire) begin
                        err_q[1] <= 1'b1;
                        state    <= ST_FLUSH;
                        bit_buf  <= '0;
                        bit_cnt  <= '0;
                    end
                end
                default: begin
                    bit_buf <= '0;
                    bit_cnt <= '0;
                    if (level == '0) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign enc_start   = enc_start_q;
    assign enc_bin_msg = bit_buf[15];
    assign frame_done  = frame_done_q;
    assign err         = err_q;
    assign out_valid   = out_valid_q;
    assign out_word    = out_word_q;
    assign out_idx     = out_idx_q;
    assign out_last    = out_last_q;

endmodule

// File: tb/tb_cw_encode_ctrl.sv
// Directed bench for cw_encode_ctrl: bit serialisation, full/short frames,
// output backpressure, watchdog timeout and mid-frame reset.
module tb_cw_encode_ctrl;

    localparam int CW  = 38;
    localparam int TMO = 1023;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       busy;
    logic       msg_valid;
    logic [7:0] msg_byte;
    logic       msg_ready;
    logic       enc_start;
    logic       enc_bin_msg;
    logic       enc_fifoempty;
    logic       enc_readfifo;
    logic [9:0] enc_cw_word;
    logic       enc_ready;
    logic       enc_done;
    logic       out_valid;
    logic [9:0] out_word;
    logic [5:0] out_idx;
    logic       out_last;
    logic       out_ready;
    logic       frame_done;
    logic [1:0] err;

    int n_assert = 0;
    int n_fail   = 0;

    cw_encode_ctrl #(.CW_WORDS(CW), .OFIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy),
        .msg_valid(msg_valid), .msg_byte(msg_byte), .msg_ready(msg_ready),
        .enc_start(enc_start), .enc_bin_msg(enc_bin_msg), .enc_fifoempty(enc_fifoempty),
        .enc_readfifo(enc_readfifo), .enc_cw_word(enc_cw_word), .enc_ready(enc_ready),
        .enc_done(enc_done), .out_valid(out_valid), .out_word(out_word),
        .out_idx(out_idx), .out_last(out_last), .out_ready(out_ready),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] cw_val(input int i);
        return 10'((i * 37 + 11) % 1024);
    endfunction

    // One codeword every other cycle with out_ready=1: each word is visible for one cycle.
    task automatic send_words(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            enc_cw_word = cw_val(i);
            enc_ready   = 1'b1;
            tick();
            enc_ready = 1'b0;
            chk("word_valid", 32'(out_valid), 32'd1);
            chk("word_data",  32'(out_word),  32'(cw_val(i)));
            chk("word_idx",   32'(out_idx),   32'(i));
            chk("word_last",  32'(out_last),  32'(i == CW - 1));
            tick();
        end
    endtask

    task automatic wait_frame_done();
        int seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (frame_done) seen++;
        end
        chk("frame_done_count", 32'(seen), 32'd1);
        chk("busy_after_frame", 32'(busy), 32'd0);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("enc_start_pulse", 32'(enc_start), 32'd1);
        chk("busy_on_start",   32'(busy),      32'd1);
        tick();
        chk("enc_start_one_cycle", 32'(enc_start), 32'd0);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_busy"},      32'(busy),          32'd0);
        chk({pfx, "_msg_ready"}, 32'(msg_ready),     32'd0);
        chk({pfx, "_enc_start"}, 32'(enc_start),     32'd0);
        chk({pfx, "_bin_msg"},   32'(enc_bin_msg),   32'd0);
        chk({pfx, "_fifoempty"}, 32'(enc_fifoempty), 32'd1);
        chk({pfx, "_out_valid"}, 32'(out_valid),     32'd0);
        chk({pfx, "_out_word"},  32'(out_word),      32'd0);
        chk({pfx, "_out_idx"},   32'(out_idx),       32'd0);
        chk({pfx, "_out_last"},  32'(out_last),      32'd0);
        chk({pfx, "_frame_done"},32'(frame_done),    32'd0);
        chk({pfx, "_err"},       32'(err),           32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [15:0] seq;
        int t;

        rst = 1'b1;
        frame_start = 1'b0; msg_valid = 1'b0; msg_byte = '0;
        enc_readfifo = 1'b0; enc_cw_word = '0; enc_ready = 1'b0;
        enc_done = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_reset_values("reset");

        // Frame 1: bit order, count +7, then full 38-word frame
        start_frame();
        chk("idle_buf_ready", 32'(msg_ready),     32'd1);
        chk("idle_buf_empty", 32'(enc_fifoempty), 32'd1);
        msg_valid = 1'b1; msg_byte = 8'hA5;
        tick();
        chk("cnt8_ready",    32'(msg_ready),     32'd1);
        chk("cnt8_notempty", 32'(enc_fifoempty), 32'd0);
        msg_byte = 8'h3C;
        tick();
        msg_valid = 1'b0;
        chk("cnt16_ready", 32'(msg_ready), 32'd0);
        seq = 16'hA53C;
        enc_readfifo = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("bit_order", 32'(enc_bin_msg), 32'(seq[15 - i]));
            if (i == 7) chk("cnt9_ready", 32'(msg_ready), 32'd0);
            if (i == 8) chk("cnt8b_ready", 32'(msg_ready), 32'd1);
            tick();
        end
        enc_readfifo = 1'b0;
        chk("drained_empty", 32'(enc_fifoempty), 32'd1);

        msg_valid = 1'b1; msg_byte = 8'h80;
        tick();
        chk("p7_head", 32'(enc_bin_msg), 32'd1);
        msg_byte = 8'h01; enc_readfifo = 1'b1;
        tick();
        msg_valid = 1'b0;
        chk("p7_cnt15_ready", 32'(msg_ready), 32'd0);
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 6)  chk("p7_cnt9_ready", 32'(msg_ready), 32'd0);
            if (k == 7)  chk("p7_cnt8_ready", 32'(msg_ready), 32'd1);
            if (k == 14) chk("p7_last_bit",   32'(enc_bin_msg), 32'd1);
        end
        tick();
        enc_readfifo = 1'b0;
        chk("p7_empty", 32'(enc_fifoempty), 32'd1);

        send_words(0, CW);
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        chk("full_err", 32'(err), 32'd0);
        wait_frame_done();
        chk("full_err_idle", 32'(err), 32'd0);

        // Frame 2: backpressure, stalled pop, then short frame (37 words)
        start_frame();
        out_ready = 1'b0;
        msg_valid = 1'b1; msg_byte = 8'h80;
        tick();
        msg_valid = 1'b0;
        chk("bp_not_empty0", 32'(enc_fifoempty), 32'd0);
        for (int i = 0; i < 3; i++) begin
            enc_cw_word = cw_val(i); enc_ready = 1'b1;
            tick();
            enc_ready = 1'b0;
            chk("bp_fifoempty", 32'(enc_fifoempty), 32'(i == 2));
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_head_idx",  32'(out_idx),   32'd0);
        enc_readfifo = 1'b1;
        tick();
        enc_readfifo = 1'b0;
        chk("bp_pop_ignored", 32'(enc_bin_msg), 32'd1);
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk("bp_resume_idx",  32'(out_idx),  32'(j));
            chk("bp_resume_word", 32'(out_word), 32'(cw_val(j)));
            tick();
        end
        chk("bp_drained",     32'(out_valid),     32'd0);
        chk("bp_unstalled",   32'(enc_fifoempty), 32'd0);
        send_words(3, CW - 4);
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        chk("short_err", 32'(err), 32'd1);
        wait_frame_done();
        chk("short_err_sticky", 32'(err), 32'd1);

        // Frame 3: silent core -> watchdog
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("err_cleared",  32'(err),           32'd0);
        chk("buf_cleared",  32'(enc_bin_msg),   32'd0);
        chk("buf_cleared_empty", 32'(enc_fifoempty), 32'd1);
        t = 0;
        while (err == 2'b00 && t < TMO + 50) begin
            tick();
            t++;
        end
        chk("timeout_cycles", 32'(t),    32'(TMO + 1));
        chk("timeout_err",    32'(err),  32'd2);
        chk("timeout_busy",   32'(busy), 32'd1);
        wait_frame_done();

        // Frame 4: reset at word 20, then a clean frame
        start_frame();
        msg_valid = 1'b1; msg_byte = 8'h80;
        tick();
        msg_valid = 1'b0;
        send_words(0, 20);
        out_ready = 1'b0;
        enc_cw_word = cw_val(20); enc_ready = 1'b1;
        tick();
        enc_ready = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_idx",   32'(out_idx),   32'd20);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        start_frame();
        send_words(0, CW);
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        chk("post_rst_err", 32'(err), 32'd0);
        wait_frame_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cw_encode_ctrl.md
# cw_encode_ctrl

Sequencer for the constant-weight encoder core (`encoder_main`).
- **Input side:** accepts message bytes from a host over a valid/ready handshake and serialises them into a 16-bit bit buffer, which feeds the core's FIFO-style bit interface.
- **Control:** issues the per-frame `start` pulse and applies backpressure to the core.
- **Output side:** captures every 10-bit codeword on `enc_ready` into a small output FIFO with index and last tags.
- **Checks:** detects a short or long frame and a stalled core.

## Interface
Parameters:
- CW_WORDS, 38: codeword entries per frame (core weight t).
- OFIFO_DEPTH, 4: output FIFO depth (power of two, ≥ 4).
- TIMEOUT, 1023: maximum idle cycles in RUN before error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle request to encode one frame
- busy  out  1  high from accepted frame_start until return to IDLE
- msg_valid  in  1  host byte valid
- msg_byte  in  8  message byte, shifted out MSB first
- msg_ready  out  1  byte accepted when msg_valid & msg_ready
- enc_start  out  1  one-cycle start to core
- enc_bin_msg  out  1  head bit of bit buffer
- enc_fifoempty  out  1  empty/stall indication to core
- enc_readfifo  in  1  core pops head bit
- enc_cw_word  in  10  core codeword
- enc_ready  in  1  core codeword-valid pulse
- enc_done  in  1  core frame-complete pulse
- out_valid  out  1  output FIFO non-empty
- out_word  out  10  codeword at FIFO head
- out_idx  out  6  index of head word, 0..CW_WORDS-1
- out_last  out  1  head word index == CW_WORDS-1
- out_ready  in  1  consumer pop
- frame_done  out  1  one-cycle pulse at frame end
- err  out  2  sticky flags: bit0 word-count mismatch, bit1 timeout; cleared by the next accepted frame_start

## Operation
States:
- **IDLE:** reached on reset. On frame_start: clear the bit buffer, word counter and watchdog, clear err, go to START. frame_start is ignored outside IDLE.
- **START:** drive enc_start=1 for exactly one cycle, then go to RUN.
- **RUN:**
  - **Byte intake:** msg_ready = (bit count ≤ 8). An accepted byte is appended behind the existing bits; count += 8.
  - **Bit pop:** an enc_readfifo while the buffer is non-empty removes the head bit; count -= 1. An enc_readfifo while enc_fifoempty=1 is ignored.
  - **Same-cycle pop and append:** the count updates by +7.
  - **enc_fifoempty** = (count==0) OR (output FIFO free slots < 2). Holding it high stalls the core in its best_d state, so no codeword is ever lost.
  - **enc_ready:** push {enc_cw_word, word counter} into the output FIFO; the counter increments and saturates at 63.
  - **enc_done:** if counter ≠ CW_WORDS, set err[0]. Go to FLUSH.
  - **Watchdog:** counts cycles with none of enc_readfifo, enc_ready or msg acceptance, and resets on any of them. When it reaches TIMEOUT: set err[1] and go to FLUSH.
- **FLUSH:** discard the buffer (count=0), msg_ready=0. Wait until the output FIFO is empty, then pulse frame_done and go to IDLE.

Output FIFO: out_valid, out_word, out_idx and out_last reflect the head entry. A push and a pop in the same cycle are both performed.

Reset values: busy 0, msg_ready 0, enc_start 0, enc_bin_msg 0, enc_fifoempty 1, out_valid 0, out_word 0, out_idx 0, out_last 0, frame_done 0, err 0. Asserting rst mid-frame returns to IDLE immediately, clears all buffers and drops codewords in flight.

## Timing
- All outputs are registered except msg_ready and enc_fifoempty, which are combinational from registered count/level.
- frame_start accepted at edge N: enc_start=1 in cycle N+1, RUN from N+2.
- enc_bin_msg updates on the edge after a pop or after an append into an empty buffer.
- enc_ready at edge N: out_valid=1 from cycle N+1 if the FIFO was empty.
- frame_done fires at the earliest one cycle after the final pop that empties the FIFO.

## Test plan
1. Full frame: 38 enc_ready pulses, then enc_done, out_ready held 1 → 38 words with out_idx 0..37, out_last only on idx 37, one frame_done, err=0.
2. Backpressure: out_ready=0 after 3 words → enc_fifoempty=1 while free slots <2, no drops. Release → words resume in order.
3. Bit order: bytes 0xA5, 0x3C, pops every cycle → enc_bin_msg sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. msg_ready stays low while count >8. Same-cycle pop and append gives count +7.
4. Short frame: enc_done after 37 words → err=01, frame_done after drain. The next frame_start clears err.
5. Timeout: enc_start issued, core silent for TIMEOUT cycles → err=10, FLUSH, IDLE.
6. Reset mid-frame at word 20 → next cycle all outputs at reset values, busy 0. A new frame then completes normally.
